serial_add_sequencer: RTL and testbench

//   Multi-cycle sequencer that time-shares one 2-bit ripple adder slice (a0,b0,cin -> s0; a1,b1 -> s1, cout)
//   to add two WIDTH-bit operands, processing one 2-bit digit per cycle, LSB digit first.

---
 rtl/serial_add_sequencer_if.sv | 43 ++++
 rtl/serial_add_sequencer.sv | 165 ++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_if.sv
// Handshake bundle for serial_add_sequencer: operand side (in_*) and result side (out_*).
// Optional feature macro: SERADD_OVF_EN adds the out_ovf signal to the bundle.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef SERADD_OVF_EN
    logic             out_ovf;

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy, out_ovf
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy, out_ovf
    );
`else
    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`endif
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: adds two WIDTH-bit operands by time-sharing one 2-bit ripple
// adder slice, one digit per clock, LSB digit first. The carry lives in a register
// between digits. Operands are latched into shift registers at accept so that the
// producer may change in_* afterwards; the sum is built in a shift register that
// fills from the top, so after N digits it is aligned.
// Optional feature macro: SERADD_OVF_EN adds out_ovf, the signed two's-complement
// overflow flag (carry into MSB xor carry out of MSB), captured on the last digit.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_sequencer_if.slave bus
);
    localparam int N     = WIDTH / 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               out_valid_q, out_valid_d;
    logic               cout_q, cout_d;
    logic [2:0]         slice_w;     // {cout, s1, s0}
    logic               last_digit_w;
`ifdef SERADD_OVF_EN
    logic               ovf_q, ovf_d;
    logic               c_msb_in_w;  // carry from bit 0 into bit 1 of the slice
`endif

    // 2-bit ripple adder slice: a0,b0,cin -> s0; a1,b1 -> s1, cout
    function automatic logic [2:0] add_slice(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic       c
    );
        logic s0;
        logic c1;
        logic s1;
        logic c2;
        s0 = a[0] ^ b[0] ^ c;
        c1 = (a[0] & b[0]) | (a[0] & c) | (b[0] & c);
        s1 = a[1] ^ b[1] ^ c1;
        c2 = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
        return {c2, s1, s0};
    endfunction

    // Slice inputs always come from the low digit of the operand shift registers
    always_comb begin
        slice_w      = add_slice(a_q[1:0], b_q[1:0], carry_q);
        last_digit_w = (cnt_q == CNT_W'(N - 1));
    end

`ifdef SERADD_OVF_EN
    // Internal carry of the slice, needed only for the signed overflow flag
    always_comb begin
        c_msb_in_w = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end
`endif

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
`ifdef SERADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
`ifdef SERADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update: accept in IDLE, one digit per cycle in RUN,
    // hold the result in DONE until the consumer takes it
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;
`ifdef SERADD_OVF_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d                 = a_q >> 2;
                b_d                 = b_q >> 2;
                sum_d               = sum_q >> 2;
                sum_d[WIDTH-1 -: 2] = slice_w[1:0];
                carry_d             = slice_w[2];
                cnt_d               = cnt_q + CNT_W'(1);
                if (last_digit_w) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = slice_w[2];
`ifdef SERADD_OVF_EN
                    ovf_d       = c_msb_in_w ^ slice_w[2];
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Output decode; the sum is only exposed while the result is presented
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = out_valid_q;
        bus.out_sum   = out_valid_q ? sum_q : '0;
        bus.out_cout  = cout_q;
`ifdef SERADD_OVF_EN
        bus.out_ovf   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Testbench for serial_add_sequencer: random and directed operations on a WIDTH=8
// instance checked every cycle against a transaction-level model, plus a WIDTH=2
// instance swept exhaustively. Honours SERADD_OVF_EN when defined.
module tb_serial_add_sequencer;
    localparam int W  = 8;
    localparam int NW = W / 2;

    logic clk;
    logic rst_n;

    serial_add_sequencer_if #(.WIDTH(W)) u_if8 ();
    serial_add_sequencer_if #(.WIDTH(2)) u_if2 ();

    serial_add_sequencer #(.WIDTH(W)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if8)
    );

    serial_add_sequencer #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted operation becomes presentable N edges
    // after acceptance and disappears on the consumer's handshake.
    int          cyc      = 0;
    int          m_acc    = 0;
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    logic [W:0]  m_res    = '0;
    logic        m_ovf    = 1'b0;

    always @(posedge clk) begin
        int sa;
        int sb;
        int ss;
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (!m_active) begin
            if (u_if8.in_valid) begin
                m_active = 1'b1;
                m_acc    = cyc;
                m_res    = {1'b0, u_if8.in_a} + {1'b0, u_if8.in_b} + {{W{1'b0}}, u_if8.in_cin};
                sa       = int'($signed(u_if8.in_a));
                sb       = int'($signed(u_if8.in_b));
                ss       = sa + sb + int'(u_if8.in_cin);
                m_ovf    = (ss > 127) || (ss < -128);
            end
        end else if (!m_done) begin
            if (cyc - m_acc == NW) m_done = 1'b1;
        end else if (u_if8.out_ready) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end
    end

    // Per-cycle comparison of the WIDTH=8 instance against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", u_if8.out_valid, 1'b0);
            check("rst_busy", u_if8.busy, 1'b0);
            check("rst_out_sum", u_if8.out_sum, '0);
        end else begin
            check("in_ready", u_if8.in_ready, !m_active);
            check("busy", u_if8.busy, m_active);
            check("out_valid", u_if8.out_valid, m_done);
            if (m_done) begin
                check("out_sum", u_if8.out_sum, m_res[W-1:0]);
                check("out_cout", u_if8.out_cout, m_res[W]);
`ifdef SERADD_OVF_EN
                check("out_ovf", u_if8.out_ovf, m_ovf);
`endif
            end else begin
                check("out_sum_idle", u_if8.out_sum, '0);
            end
        end
    end

    // One operation on the WIDTH=8 instance; optional literal expectations,
    // backpressure for 'hold' cycles and scrambling of inputs after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, input bit scramble, input bit lit,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int guard;
        int lat;
        u_if8.in_a     = a;
        u_if8.in_b     = b;
        u_if8.in_cin   = cin;
        u_if8.in_valid = 1'b1;
        guard = 0;
        while (!u_if8.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 1'b1, 1'b0);
        @(posedge clk); #1;
        u_if8.in_valid = 1'b0;
        if (scramble) begin
            u_if8.in_a   = W'($urandom);
            u_if8.in_b   = W'($urandom);
            u_if8.in_cin = 1'($urandom);
        end
        lat = 0;
        while (!u_if8.out_valid && lat < 40) begin
            if (lit) check("lit_in_ready_run", u_if8.in_ready, 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        if (lit) begin
            check("lit_latency", lat, NW);
            check("lit_sum", u_if8.out_sum, exp_sum);
            check("lit_cout", u_if8.out_cout, exp_cout);
            check("model_sum", m_res[W-1:0], exp_sum);
            check("model_cout", m_res[W], exp_cout);
`ifdef SERADD_OVF_EN
            check("lit_ovf", u_if8.out_ovf, exp_ovf);
            check("model_ovf", m_ovf, exp_ovf);
`else
            if (exp_ovf === 1'bx) check("lit_ovf_arg", 1'b0, 1'b1);
`endif
        end else if (lat >= 40) begin
            check("result_timeout", 1'b1, 1'b0);
        end
        for (int i = 0; i < hold; i++) begin
            u_if8.in_valid = 1'($urandom);
            u_if8.in_a     = W'($urandom);
            u_if8.in_b     = W'($urandom);
            @(posedge clk); #1;
            if (lit) begin
                check("bp_in_ready", u_if8.in_ready, 1'b0);
                check("bp_sum", u_if8.out_sum, exp_sum);
                check("bp_cout", u_if8.out_cout, exp_cout);
            end
        end
        u_if8.in_valid  = 1'b0;
        u_if8.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if8.out_ready = 1'b0;
        if (lit) check("post_hs_in_ready", u_if8.in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r2;
        rst_n = 1'b1;
        u_if8.in_valid = 1'b0; u_if8.in_a = '0; u_if8.in_b = '0; u_if8.in_cin = 1'b0;
        u_if8.out_ready = 1'b0;
        u_if2.in_valid = 1'b0; u_if2.in_a = '0; u_if2.in_b = '0; u_if2.in_cin = 1'b0;
        u_if2.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_out_valid", u_if8.out_valid, 1'b0);
        check("reset_busy", u_if8.busy, 1'b0);
        check("reset_out_sum", u_if8.out_sum, '0);
        check("reset_out_cout", u_if8.out_cout, 1'b0);
`ifdef SERADD_OVF_EN
        check("reset_out_ovf", u_if8.out_ovf, 1'b0);
`endif
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", u_if8.in_ready, 1'b1);

        // Directed operations with hand-computed results
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 5, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b1, 1'b1, 8'h46, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        run_op(8'h80, 8'hFF, 1'b0, 1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Reset in the middle of RUN (after two digits)
        u_if8.in_a = 8'h3C; u_if8.in_b = 8'h0F; u_if8.in_cin = 1'b1; u_if8.in_valid = 1'b1;
        @(posedge clk); #1;
        u_if8.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", u_if8.out_valid, 1'b0);
        check("abort_busy", u_if8.busy, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #2;
        check("abort_in_ready", u_if8.in_ready, 1'b1);
        @(posedge clk); #1;
        run_op(8'h3C, 8'h0F, 1'b1, 0, 1'b0, 1'b1, 8'h4C, 1'b0, 1'b0);

        // Random operations; the per-cycle compare checks every result
        for (int k = 0; k < 60; k++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                @(posedge clk); #1;
            end
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3),
                   1'($urandom), 1'b0, '0, 1'b0, 1'b0);
        end

        // WIDTH=2 instance: literal case, then exhaustive sweep, one edge of RUN each
        for (int v = -1; v < 32; v++) begin
            logic [1:0] ea;
            logic [1:0] eb;
            logic       ec;
            if (v < 0) begin
                ea = 2'b11; eb = 2'b01; ec = 1'b0;
            end else begin
                ea = 2'(v >> 3); eb = 2'(v >> 1); ec = 1'(v);
            end
            r2 = (v < 0) ? 3'b100 : ({1'b0, ea} + {1'b0, eb} + {2'b00, ec});
            check("w2_in_ready", u_if2.in_ready, 1'b1);
            u_if2.in_a = ea; u_if2.in_b = eb; u_if2.in_cin = ec; u_if2.in_valid = 1'b1;
            @(posedge clk); #1;
            u_if2.in_valid = 1'b0;
            check("w2_busy", u_if2.busy, 1'b1);
            check("w2_not_valid_yet", u_if2.out_valid, 1'b0);
            @(posedge clk); #1;
            check("w2_out_valid", u_if2.out_valid, 1'b1);
            check("w2_sum", u_if2.out_sum, r2[1:0]);
            check("w2_cout", u_if2.out_cout, r2[2]);
            u_if2.out_ready = 1'b1;
            @(posedge clk); #1;
            u_if2.out_ready = 1'b0;
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
